// File: rtl/ram_rmw_accum_pkg.sv
// Shared definitions for the BRAM read-modify-write accumulator.
// State encoding and the saturation constant (used when RMW_ACCUM_SAT_EN is defined).
package ram_rmw_accum_pkg;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DUMP_RD,
        S_DUMP_CAP,
        S_DUMP_OUT
    } state_e;

    localparam int unsigned MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] SAT_ONES = {MAX_WIDTH{1'b1}};

endpackage

// File: rtl/ram_rmw_accum_fwd.sv
// Stage-B add datapath with write-back register and back-to-back forwarding.
// Define RMW_ACCUM_SAT_EN to saturate the sum instead of wrapping.
module rmw_accum_fwd
    import ram_rmw_accum_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned ADDR_BITS   = 11,
    parameter int unsigned DELTA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   b_valid_i,
    input  logic [ADDR_BITS-1:0]   b_addr_i,
    input  logic [DELTA_WIDTH-1:0] b_delta_i,
    input  logic [WIDTH-1:0]       mem_r_data_i,
    output logic [WIDTH-1:0]       sum_o
);

    logic                 wb_valid_q;
    logic [ADDR_BITS-1:0] wb_addr_q;
    logic [WIDTH-1:0]     wb_data_q;
    logic                 fwd_hit;
    logic [WIDTH-1:0]     operand;

    // The previous cycle's write is not yet visible to the read issued alongside it.
    assign fwd_hit = wb_valid_q && (wb_addr_q == b_addr_i);
    assign operand = fwd_hit ? wb_data_q : mem_r_data_i;

`ifdef RMW_ACCUM_SAT_EN
    logic [WIDTH:0] raw;
    assign raw   = {1'b0, operand} + (WIDTH+1)'(b_delta_i);
    assign sum_o = raw[WIDTH] ? SAT_ONES[WIDTH-1:0] : raw[WIDTH-1:0];
`else
    assign sum_o = operand + WIDTH'(b_delta_i);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= b_valid_i;
            if (b_valid_i) begin
                wb_addr_q <= b_addr_i;
                wb_data_q <= sum_o;
            end
        end
    end

endmodule

// File: rtl/ram_rmw_accum.sv
// Read-modify-write accumulator in front of a 1-cycle-latency BRAM, with clear and dump.
// Optional macro RMW_ACCUM_SAT_EN selects saturating instead of wrapping sums.
module ram_rmw_accum
    import ram_rmw_accum_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned ADDR_BITS   = 11,
    parameter int unsigned DELTA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_BITS-1:0]   in_addr,
    input  logic [DELTA_WIDTH-1:0] in_delta,
    input  logic                   dump_start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_BITS-1:0]   out_addr,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   mem_we,
    output logic [ADDR_BITS-1:0]   mem_w_addr,
    output logic [WIDTH-1:0]       mem_w_data,
    output logic [ADDR_BITS-1:0]   mem_r_addr,
    input  logic [WIDTH-1:0]       mem_r_data
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic                   b_valid_q, b_valid_d;
    logic [ADDR_BITS-1:0]   b_addr_q, b_addr_d;
    logic [DELTA_WIDTH-1:0] b_delta_q, b_delta_d;
    logic                   out_valid_q, out_valid_d;
    logic [ADDR_BITS-1:0]   out_addr_q, out_addr_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   we;
    logic [WIDTH-1:0]       b_sum;

    rmw_accum_fwd #(
        .WIDTH       (WIDTH),
        .ADDR_BITS   (ADDR_BITS),
        .DELTA_WIDTH (DELTA_WIDTH)
    ) u_fwd (
        .clk          (clk),
        .rst          (rst),
        .b_valid_i    (b_valid_q),
        .b_addr_i     (b_addr_q),
        .b_delta_i    (b_delta_q),
        .mem_r_data_i (mem_r_data),
        .sum_o        (b_sum)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        b_valid_d   = 1'b0;
        b_addr_d    = b_addr_q;
        b_delta_d   = b_delta_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;
        we          = 1'b0;
        mem_w_addr  = '0;
        mem_w_data  = '0;
        mem_r_addr  = '0;

        if (b_valid_q) begin
            we         = 1'b1;
            mem_w_addr = b_addr_q;
            mem_w_data = b_sum;
        end

        unique case (state_q)
            S_CLEAR: begin
                we         = 1'b1;
                mem_w_addr = idx_q;
                mem_w_data = '0;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    idx_d = idx_q + ADDR_BITS'(1);
                end
            end
            S_RUN: begin
                in_ready   = 1'b1;
                mem_r_addr = in_addr;
                if (in_valid) begin
                    b_valid_d = 1'b1;
                    b_addr_d  = in_addr;
                    b_delta_d = in_delta;
                end
                if (dump_start) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!b_valid_q) begin
                    idx_d   = '0;
                    state_d = S_DUMP_RD;
                end
            end
            S_DUMP_RD: begin
                mem_r_addr = idx_q;
                state_d    = S_DUMP_CAP;
            end
            S_DUMP_CAP: begin
                out_data_d  = mem_r_data;
                out_addr_d  = idx_q;
                out_last_d  = (idx_q == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        idx_d   = '0;
                        state_d = S_CLEAR;
                    end else begin
                        idx_d   = idx_q + ADDR_BITS'(1);
                        state_d = S_DUMP_RD;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Write enable is forced low while reset is held; CLEAR begins on release.
    assign mem_we    = we && !rst;
    assign busy      = (state_q != S_RUN);
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_CLEAR;
            idx_q       <= '0;
            b_valid_q   <= 1'b0;
            b_addr_q    <= '0;
            b_delta_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            b_valid_q   <= b_valid_d;
            b_addr_q    <= b_addr_d;
            b_delta_q   <= b_delta_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_ram_rmw_accum.sv
// Self-checking bench for ram_rmw_accum: BRAM model, accumulator model, dump scoreboard.
module tb_ram_rmw_accum;

    localparam int W  = 17;
    localparam int D  = 2048;
    localparam int A  = 11;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [A-1:0]  in_addr;
    logic [DW-1:0] in_delta;
    logic          dump_start;
    logic          out_valid;
    logic          out_ready;
    logic [A-1:0]  out_addr;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          mem_we;
    logic [A-1:0]  mem_w_addr;
    logic [W-1:0]  mem_w_data;
    logic [A-1:0]  mem_r_addr;
    logic [W-1:0]  mem_r_data;

    logic [W-1:0]  bram [D];

    longint unsigned model [D];
    int total = 0;
    int bad = 0;
    int exp_idx = 0;
    int dumps_done = 0;
    bit held_v = 0;
    logic [A-1:0] held_addr;
    logic [W-1:0] held_data;

    ram_rmw_accum #(
        .WIDTH(W), .DEPTH(D), .ADDR_BITS(A), .DELTA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_delta(in_delta),
        .dump_start(dump_start),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy),
        .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    // BRAM: 1-cycle read latency, read-old-data on same-address collision.
    always @(posedge clk) begin
        if (mem_we) bram[mem_w_addr] <= mem_w_data;
        mem_r_data <= bram[mem_r_addr];
    end

    function automatic longint unsigned acc(input longint unsigned a,
                                            input longint unsigned d);
        longint unsigned s;
        longint unsigned mx;
        s  = a + d;
        mx = (64'd1 << W) - 64'd1;
`ifdef RMW_ACCUM_SAT_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: model bookkeeping plus per-cycle dump/hold checks.
    always @(negedge clk) begin
        if (rst) begin
            exp_idx = 0;
            held_v  = 0;
            for (int i = 0; i < D; i++) model[i] = 0;
        end else begin
            if (in_valid && in_ready)
                model[in_addr] = acc(model[in_addr], 64'(in_delta));
            if (held_v) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_addr", 64'(out_addr), 64'(held_addr));
                chk("hold_data", 64'(out_data), 64'(held_data));
            end
            held_v    = out_valid && !out_ready;
            held_addr = out_addr;
            held_data = out_data;
            if (out_valid && out_ready) begin
                chk("dump_addr", 64'(out_addr), 64'(exp_idx));
                chk("dump_data", 64'(out_data), model[exp_idx]);
                chk("dump_last", 64'(out_last), 64'(exp_idx == D - 1));
                if (exp_idx == D - 1) begin
                    exp_idx = 0;
                    for (int i = 0; i < D; i++) model[i] = 0;
                    dumps_done++;
                end else begin
                    exp_idx++;
                end
            end
        end
    end

    task automatic push(input int a, input int d);
        in_valid = 1'b1;
        in_addr  = A'(a);
        in_delta = DW'(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_run(input string name);
        int cyc = 0;
        while (busy && cyc < D + 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic run_dump(input bit stall, input bit with_upd);
        int target;
        int stalled;
        int cyc;
        target  = dumps_done + 1;
        stalled = 0;
        cyc     = 0;
        dump_start = 1'b1;
        if (with_upd) begin
            in_valid = 1'b1;
            in_addr  = A'(30);
            in_delta = DW'(7);
        end
        @(posedge clk); #1;
        dump_start = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        chk("ready_drop", 64'(in_ready), 64'd0);
        chk("busy_dump", 64'(busy), 64'd1);
        if (with_upd) chk("pin_same_cycle_upd", model[30], 64'd7);
        @(posedge clk); #1;
        while (dumps_done < target && cyc < 4 * D + 64) begin
            if (stall && out_valid && out_addr == A'(3) && stalled < 6) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b1;
        chk("dump_complete", 64'(dumps_done), 64'(target));
        if (stall) chk("stall_cycles", 64'(stalled), 64'd6);
    endtask

    initial begin
        int clr_err;
        int cyc;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_addr    = '0;
        in_delta   = '0;
        dump_start = 1'b0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_w_addr", 64'(mem_w_addr), 64'd0);
        chk("rst_w_data", 64'(mem_w_data), 64'd0);
        chk("rst_r_addr", 64'(mem_r_addr), 64'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        clr_err = 0;
        for (int i = 0; i < D; i++) begin
            @(negedge clk);
            if (!(busy && mem_we && mem_w_addr == A'(i) && mem_w_data == '0))
                clr_err++;
        end
        chk("clear_sweep_errs", 64'(clr_err), 64'd0);
        @(negedge clk);
        chk("run_busy", 64'(busy), 64'd0);
        chk("run_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        push(5, 3);  idle(2);
        push(9, 4);  idle(1);
        push(5, 10); idle(2);
        for (int i = 0; i < 4; i++) push(7, 1);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            push(10, 1);
            push(11, 1);
        end
        idle(1);
        push(20, 16'hFFFF); idle(1);
        push(20, 16'hFFFF);
        push(20, 5);
        idle(3);

        chk("pin_e5", model[5], 64'd13);
        chk("pin_e9", model[9], 64'd4);
        chk("pin_e7", model[7], 64'd4);
        chk("pin_e10", model[10], 64'd4);
        chk("pin_e11", model[11], 64'd4);
`ifdef RMW_ACCUM_SAT_EN
        chk("pin_e20", model[20], 64'd131071);
`else
        chk("pin_e20", model[20], 64'd3);
`endif

        run_dump(1'b1, 1'b1);
        wait_run("autoclear_done");
        run_dump(1'b0, 1'b0);
        wait_run("autoclear2_done");

        dump_start = 1'b1;
        @(posedge clk); #1;
        dump_start = 1'b0;
        cyc = 0;
        while (!(out_valid && out_addr == A'(100)) && cyc < 4 * D) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_entry100", 64'(out_addr), 64'd100);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_addr", 64'(out_addr), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        chk("midrst_out_last", 64'(out_last), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd1);
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reclear_we", 64'(mem_we), 64'd1);
        chk("reclear_addr0", 64'(mem_w_addr), 64'd0);
        @(negedge clk);
        chk("reclear_addr1", 64'(mem_w_addr), 64'd1);
        @(posedge clk); #1;
        wait_run("reclear_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
